stage_one: RTL

//  Instruction-fetch stage of the MUSA core; sits directly upstream of the decode stage.

---
 rtl/stage_one.sv | 136 +++++++++++++
 1 files changed

// File: rtl/stage_one.sv
// Instruction-fetch stage: PC register, next-PC select, return-address stack
// and the IF/ID pipeline register feeding decode.
module stage_one #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pcSrc,
    input  logic        PCWrite,
    input  logic        push,
    input  logic        pop,
    input  logic [25:0] out_jump,
    input  logic [31:0] word_sign,
    input  logic [31:0] readData1,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] id_pc4,
    output logic        stack_empty,
    output logic        stack_full,
    output logic        stack_err
);

    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = AW + 1;

    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [31:0]    id_pc4_q, id_pc4_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic [31:0]    stack_q [STACK_DEPTH];

    logic           wr_en;
    logic [AW-1:0]  wr_idx;
    logic [SPW-1:0] sp_m1;
    logic [31:0]    pc4, br_target, ret_target;
    logic           redirect;

    assign sp_m1       = sp_q - SPW'(1);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stack_err   = err_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign id_pc4      = id_pc4_q;

    assign pc4        = pc_q + 32'd4;
    assign br_target  = id_pc4_q + {word_sign[29:0], 2'b00};
    // Return target always reads the top before any same-cycle stack update.
    assign ret_target = stack_empty ? RESET_PC : stack_q[sp_m1[AW-1:0]];

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        id_pc4_d = id_pc4_q;
        redirect = 1'b0;
        if (PCWrite) begin
            redirect = 1'b1;
            case (pcSrc)
                3'b001:  pc_d = br_target;
                3'b010:  pc_d = {id_pc4_q[31:28], out_jump, 2'b00};
                3'b011:  pc_d = readData1;
                3'b100:  pc_d = ret_target;
                default: begin
                    pc_d     = pc4;
                    redirect = 1'b0;
                end
            endcase
            if (redirect) begin
                instr_d  = 32'd0;
                id_pc4_d = 32'd0;
            end else begin
                instr_d  = imem_rdata;
                id_pc4_d = pc4;
            end
        end
    end

    always_comb begin
        sp_d   = sp_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = sp_q[AW-1:0];
        if (PCWrite) begin
            if (push && pop) begin
                // Replace the top in place; on an empty stack this degrades to a push.
                wr_en = 1'b1;
                if (stack_empty) begin
                    wr_idx = '0;
                    sp_d   = SPW'(1);
                    err_d  = 1'b1;
                end else begin
                    wr_idx = sp_m1[AW-1:0];
                end
            end else if (push) begin
                if (!stack_full) begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + SPW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (pop) begin
                if (!stack_empty) begin
                    sp_d = sp_m1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            id_pc4_q <= 32'd0;
            sp_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            id_pc4_q <= id_pc4_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_idx] <= id_pc4_q;
        end
    end

endmodule
